// File: rtl/hyper_cmd_bridge.sv
// Bridges 5-byte UART command frames to the HyperRAM controller.
// Each frame gets exactly one 4-byte response, sent MSB first.
module hyper_cmd_bridge #(
  parameter int unsigned BYTE_TIMEOUT = 240000,
  parameter int unsigned MEM_TIMEOUT  = 1024,
  parameter logic [31:0] CONST_VALUE  = 32'd259
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_d,
  input  logic [31:0] mem_rd_d,
  input  logic        mem_rd_rdy,
  input  logic        mem_busy,
  output logic        cmd_active,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned MT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RX, S_EXEC, S_MEM_REQ, S_MEM_WAIT,
    S_TX_LOAD, S_TX_START, S_TX_WAIT_LOW, S_TX_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] frame_q, frame_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [BT_W-1:0] to_cnt_q, to_cnt_d;
  logic [MT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_d_q, mem_wr_d_d;
  logic [31:0] rd_hold_q, rd_hold_d;
  logic [31:0] op_cnt_q, op_cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        mem_rd_req_q, mem_rd_req_d;
  logic        mem_wr_req_q, mem_wr_req_d;
  logic        cmd_active_q, cmd_active_d;
  logic        overrun_q, overrun_d;
  logic        timeout_err_q, timeout_err_d;
  logic        is_rd_q, is_rd_d;
  logic        busy_seen_q, busy_seen_d;
  logic        rdy_seen_q, rdy_seen_d;
  logic        mem_done_c;

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_d    = mem_wr_d_q;
  assign cmd_active  = cmd_active_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

  // Write completes on busy high-then-low; read on rd_rdy (now or earlier) with busy low.
  assign mem_done_c = is_rd_q ? ((rdy_seen_q || mem_rd_rdy) && !mem_busy)
                              : (busy_seen_q && !mem_busy);

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    mem_cnt_d     = mem_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_d_d    = mem_wr_d_q;
    rd_hold_d     = rd_hold_q;
    op_cnt_d      = op_cnt_q;
    resp_d        = resp_q;
    tx_shift_d    = tx_shift_q;
    tx_cnt_d      = tx_cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    mem_rd_req_d  = 1'b0;
    mem_wr_req_d  = 1'b0;
    cmd_active_d  = cmd_active_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    is_rd_d       = is_rd_q;
    busy_seen_d   = busy_seen_q;
    rdy_seen_d    = rdy_seen_q;

    // Bytes arriving while a command is in flight are dropped.
    if (rx_valid && cmd_active_q) overrun_d = 1'b1;

    case (state_q)
      S_RX: begin
        if (rx_valid) begin
          frame_d  = {frame_q[31:0], rx_data};
          to_cnt_d = '0;
          if (byte_cnt_q == 3'd4) begin
            byte_cnt_d   = 3'd0;
            cmd_active_d = 1'b1;
            state_d      = S_EXEC;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (byte_cnt_q != 3'd0) begin
          if (to_cnt_q == BT_W'(BYTE_TIMEOUT - 1)) begin
            byte_cnt_d = 3'd0;
            to_cnt_d   = '0;
          end else begin
            to_cnt_d = to_cnt_q + BT_W'(1);
          end
        end
      end

      S_EXEC: begin
        state_d = S_TX_LOAD;
        case (frame_q[39:32])
          8'h01: begin mem_addr_d = frame_q[31:0]; resp_d = frame_q[31:0]; end
          8'h02: begin mem_wr_d_d = frame_q[31:0]; resp_d = frame_q[31:0]; end
          8'h03: begin is_rd_d = 1'b0; state_d = S_MEM_REQ; end
          8'h04: resp_d = rd_hold_q;
          8'h05: begin is_rd_d = 1'b1; state_d = S_MEM_REQ; end
          8'h06: begin resp_d = op_cnt_q; op_cnt_d = op_cnt_q + 32'd1; end
          8'h07: resp_d = CONST_VALUE;
          default: resp_d = 32'hFFFF_FFFF;
        endcase
      end

      S_MEM_REQ: begin
        if (!mem_busy) begin
          mem_rd_req_d = is_rd_q;
          mem_wr_req_d = !is_rd_q;
          mem_cnt_d    = '0;
          busy_seen_d  = 1'b0;
          rdy_seen_d   = 1'b0;
          state_d      = S_MEM_WAIT;
        end
      end

      S_MEM_WAIT: begin
        mem_cnt_d = mem_cnt_q + MT_W'(1);
        if (mem_busy) busy_seen_d = 1'b1;
        if (is_rd_q && mem_rd_rdy) begin
          rd_hold_d  = mem_rd_d;
          rdy_seen_d = 1'b1;
        end
        if (mem_done_c) begin
          resp_d  = is_rd_q ? (mem_rd_rdy ? mem_rd_d : rd_hold_q) : 32'h3;
          state_d = S_TX_LOAD;
        end else if (mem_cnt_q == MT_W'(MEM_TIMEOUT - 1)) begin
          resp_d        = 32'hDEAD_DEAD;
          timeout_err_d = 1'b1;
          rd_hold_d     = rd_hold_q;
          state_d       = S_TX_LOAD;
        end
      end

      S_TX_LOAD: begin
        tx_shift_d = resp_q;
        tx_cnt_d   = 3'd4;
        state_d    = S_TX_START;
      end

      S_TX_START: begin
        if (tx_ready) begin
          tx_data_d  = tx_shift_q[31:24];
          tx_start_d = 1'b1;
          state_d    = S_TX_WAIT_LOW;
        end
      end

      S_TX_WAIT_LOW: begin
        if (!tx_ready) state_d = S_TX_WAIT_HIGH;
      end

      S_TX_WAIT_HIGH: begin
        if (tx_ready) begin
          tx_shift_d = {tx_shift_q[23:0], 8'h00};
          tx_cnt_d   = tx_cnt_q - 3'd1;
          if (tx_cnt_q == 3'd1) begin
            cmd_active_d = 1'b0;
            state_d      = S_RX;
          end else begin
            state_d = S_TX_START;
          end
        end
      end

      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RX;
      frame_q       <= '0;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      mem_cnt_q     <= '0;
      mem_addr_q    <= '0;
      mem_wr_d_q    <= '0;
      rd_hold_q     <= '0;
      op_cnt_q      <= '0;
      resp_q        <= '0;
      tx_shift_q    <= '0;
      tx_cnt_q      <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      cmd_active_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      is_rd_q       <= 1'b0;
      busy_seen_q   <= 1'b0;
      rdy_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mem_cnt_q     <= mem_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_d_q    <= mem_wr_d_d;
      rd_hold_q     <= rd_hold_d;
      op_cnt_q      <= op_cnt_d;
      resp_q        <= resp_d;
      tx_shift_q    <= tx_shift_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_req_q  <= mem_wr_req_d;
      cmd_active_q  <= cmd_active_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      is_rd_q       <= is_rd_d;
      busy_seen_q   <= busy_seen_d;
      rdy_seen_q    <= rdy_seen_d;
    end
  end

endmodule
